// File: rtl/shiftreg_chain_reader.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_chain_reader
// Purpose  : Scans an external 74HC165-style parallel-in/serial-out chain.
//            Each scan pulses the parallel load, lets the chain settle, then
//            clocks WIDTH bits out of the chain MSB-first. The frame is
//            presented as a parallel word behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH    - number of bits in the external chain (2..32)
//   CLK_DIV  - system clocks per sclk half-period; also the length of the
//              load and settle phases (>= 3)
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request one scan (honoured only when idle)
//   sclk     out  chain shift clock (chain shifts on its rising edge)
//   pl_n     out  chain parallel load, active low
//   sdi      in   chain serial output (Q7), asynchronous to clk
//   data     out  captured frame, MSB = first bit shifted out
//   valid    out  data holds an unconsumed frame
//   ready    in   consumer accepts data when valid && ready
//   busy     out  scan in progress
//   overrun  out  sticky: a completed frame was dropped
// Build option:
//   SHIFTREG_READER_CONT_EN - free-running scan; start is ignored and a new
//                             scan begins as soon as the previous one ends.
// ============================================================================
module shiftreg_chain_reader #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             sclk,
  output logic             pl_n,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_LOW    = 3'd3,
    S_HIGH   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             sdi_meta;
  logic             sdi_sync;
  logic             phase_end;

`ifdef SHIFTREG_READER_CONT_EN
  // start has no function in free-running mode.
  logic unused_start;
  assign unused_start = start;
`endif

  // sdi comes from off-chip and is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_meta <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_meta <= sdi;
      sdi_sync <= sdi_meta;
    end
  end

  assign phase_end = (div_cnt == DIV_LAST);

  // All chain-facing outputs are updated on the same edge as the state
  // transition that needs them, so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      pl_n    <= 1'b1;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // Consumption; a DONE reload later in this block takes precedence.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          div_cnt <= '0;
`ifdef SHIFTREG_READER_CONT_EN
          state <= S_LOAD;
          pl_n  <= 1'b0;
          busy  <= 1'b1;
`else
          if (start) begin
            state <= S_LOAD;
            pl_n  <= 1'b0;
            busy  <= 1'b1;
          end
`endif
        end

        S_LOAD: begin
          if (phase_end) begin
            div_cnt <= '0;
            state   <= S_SETTLE;
            pl_n    <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_SETTLE: begin
          if (phase_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_LOW;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // Sample at the end of the low phase: the chain last shifted a full
        // high phase earlier, so the synchronized bit is long settled.
        S_LOW: begin
          if (phase_end) begin
            div_cnt <= '0;
            shreg   <= {shreg[WIDTH-2:0], sdi_sync};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_LAST) begin
              // Last bit taken: no trailing sclk edge, hence WIDTH-1 rises.
              state <= S_DONE;
            end else begin
              state <= S_HIGH;
              sclk  <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_HIGH: begin
          if (phase_end) begin
            div_cnt <= '0;
            state   <= S_LOW;
            sclk    <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (!valid || ready) begin
            data  <= shreg;
            valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          div_cnt <= '0;
`ifdef SHIFTREG_READER_CONT_EN
          state <= S_LOAD;
          pl_n  <= 1'b0;
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end

        default: begin
          state   <= S_IDLE;
          div_cnt <= '0;
          sclk    <= 1'b0;
          pl_n    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_chain_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_chain_reader
// Purpose  : Directed self-checking bench for shiftreg_chain_reader with a
//            behavioural 74HC165 chain model (WIDTH=16, CLK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_chain_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sclk;
  logic        pl_n;
  logic        sdi;
  logic [15:0] data;
  logic        valid;
  logic        ready = 1'b0;
  logic        busy;
  logic        overrun;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Chain model: asynchronous parallel load while pl_n is low, shift toward
  // Q7 on each sclk rise.
  logic [15:0] pattern = 16'h0000;
  logic [15:0] chain = 16'h0000;
  assign sdi = chain[15];

  always @(posedge sclk or negedge pl_n) begin
    if (!pl_n) chain <= pattern;
    else       chain <= {chain[14:0], 1'b0};
  end

  // Activity monitors
  int sclk_rises = 0;
  int pl_falls = 0;
  int pl_low_cycles = 0;
  int frames = 0;
  int idle_entries = 0;

  always @(posedge sclk) sclk_rises++;
  always @(negedge pl_n) pl_falls++;
  always @(negedge clk) if (pl_n === 1'b0) pl_low_cycles++;
  always @(posedge valid) frames++;
  always @(negedge busy) idle_entries++;

  shiftreg_chain_reader #(.WIDTH(16), .CLK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sclk    (sclk),
    .pl_n    (pl_n),
    .sdi     (sdi),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_monitors();
    sclk_rises = 0;
    pl_falls = 0;
    pl_low_cycles = 0;
    frames = 0;
    idle_entries = 0;
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns 1 time unit after the start-accepting edge.
  task automatic start_scan(input logic [15:0] p);
    pattern = p;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one scan and returns 1 time unit after the edge where busy falls.
  task automatic run_scan(input logic [15:0] p);
    bit done;
    done = 1'b0;
    start_scan(p);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!done) $display("FAIL scan_timeout: busy=%b required 0 within 400 cycles", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (sclk !== 1'b0)   $display("FAIL rst_sclk: got %b want 0", sclk);       else pass_cnt++;
    total_cnt++; if (pl_n !== 1'b1)   $display("FAIL rst_pl_n: got %b want 1", pl_n);       else pass_cnt++;
    total_cnt++; if (data !== 16'h0)  $display("FAIL rst_data: got %h want 0000", data);    else pass_cnt++;
    total_cnt++; if (valid !== 1'b0)  $display("FAIL rst_valid: got %b want 0", valid);     else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)   $display("FAIL rst_busy: got %b want 0", busy);       else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifndef SHIFTREG_READER_CONT_EN
  task automatic test_latency();
    int n;
    n = 0;
    ready = 1'b1;
    clear_monitors();
    start_scan(16'hA5C3);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        break;
      end
    end
    total_cnt++; if (n != 133)             $display("FAIL lat_cycles: got %0d want 133", n);           else pass_cnt++;
    total_cnt++; if (data !== 16'hA5C3)    $display("FAIL lat_data: got %h want a5c3", data);          else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)        $display("FAIL lat_busy: got %b want 0", busy);             else pass_cnt++;
    total_cnt++; if (sclk_rises != 15)     $display("FAIL lat_sclk_rises: got %0d want 15", sclk_rises); else pass_cnt++;
    total_cnt++; if (pl_falls != 1)        $display("FAIL lat_pl_pulses: got %0d want 1", pl_falls);   else pass_cnt++;
    total_cnt++; if (pl_low_cycles != 4)   $display("FAIL lat_pl_width: got %0d want 4", pl_low_cycles); else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (valid !== 1'b0)       $display("FAIL lat_consumed: valid=%b want 0", valid);      else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    ready = 1'b0;
    run_scan(16'h0001);
    total_cnt++; if (data !== 16'h0001)  $display("FAIL ovr_first_data: got %h want 0001", data);   else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0)   $display("FAIL ovr_first_flag: got %b want 0", overrun);  else pass_cnt++;
    run_scan(16'h8000);
    total_cnt++; if (data !== 16'h0001)  $display("FAIL ovr_data_held: got %h want 0001", data);    else pass_cnt++;
    total_cnt++; if (valid !== 1'b1)     $display("FAIL ovr_valid_held: got %b want 1", valid);    else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1)   $display("FAIL ovr_flag: got %b want 1", overrun);        else pass_cnt++;
    ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if (valid !== 1'b0)     $display("FAIL ovr_drain: valid=%b want 0", valid);       else pass_cnt++;
    total_cnt++; if (overrun !== 1'b1)   $display("FAIL ovr_sticky: got %b want 1", overrun);      else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_ready_at_done();
    do_reset();
    ready = 1'b0;
    run_scan(16'h1111);
    start_scan(16'h2222);
    repeat (132) @(posedge clk);
    #1;
    // The FSM now sits in DONE; the first frame is still pending.
    total_cnt++; if (data !== 16'h1111)  $display("FAIL rad_pre_data: got %h want 1111", data);  else pass_cnt++;
    total_cnt++; if (busy !== 1'b1)      $display("FAIL rad_pre_busy: got %b want 1", busy);     else pass_cnt++;
    ready = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++; if (data !== 16'h2222)  $display("FAIL rad_data: got %h want 2222", data);      else pass_cnt++;
    total_cnt++; if (valid !== 1'b1)     $display("FAIL rad_valid: got %b want 1", valid);       else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0)   $display("FAIL rad_overrun: got %b want 0", overrun);   else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++; if (valid !== 1'b0)     $display("FAIL rad_consumed: valid=%b want 0", valid);  else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    ready = 1'b0;
    run_scan(16'h1357);
    start_scan(16'h5A5A);
    // 70 edges after acceptance: high phase following bit 7 sample.
    repeat (70) @(posedge clk);
    #1;
    total_cnt++; if (sclk !== 1'b1)      $display("FAIL mid_pre_sclk: got %b want 1", sclk);     else pass_cnt++;
    total_cnt++; if (valid !== 1'b1)     $display("FAIL mid_pre_valid: got %b want 1", valid);   else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (sclk !== 1'b0)      $display("FAIL mid_sclk: got %b want 0", sclk);         else pass_cnt++;
    total_cnt++; if (pl_n !== 1'b1)      $display("FAIL mid_pl_n: got %b want 1", pl_n);         else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)      $display("FAIL mid_busy: got %b want 0", busy);         else pass_cnt++;
    total_cnt++; if (valid !== 1'b0)     $display("FAIL mid_valid: got %b want 0", valid);       else pass_cnt++;
    total_cnt++; if (data !== 16'h0)     $display("FAIL mid_data: got %h want 0000", data);      else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    run_scan(16'hFFFF);
    total_cnt++; if (data !== 16'hFFFF)  $display("FAIL mid_rescan_data: got %h want ffff", data); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1)     $display("FAIL mid_rescan_valid: got %b want 1", valid);  else pass_cnt++;
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b1;
    pattern = 16'h3C69;
    clear_monitors();
    @(negedge clk);
    start = 1'b1;
    // Each scan is 133 busy cycles plus one idle cycle: three scans in 402.
    repeat (402) @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++; if (pl_falls != 3)      $display("FAIL b2b_scans: got %0d want 3", pl_falls);        else pass_cnt++;
    total_cnt++; if (idle_entries != 3)  $display("FAIL b2b_idle: got %0d want 3", idle_entries);     else pass_cnt++;
    total_cnt++; if (frames != 3)        $display("FAIL b2b_frames: got %0d want 3", frames);         else pass_cnt++;
    total_cnt++; if (sclk_rises != 45)   $display("FAIL b2b_sclk_rises: got %0d want 45", sclk_rises); else pass_cnt++;
    total_cnt++; if (data !== 16'h3C69)  $display("FAIL b2b_data: got %h want 3c69", data);           else pass_cnt++;
    total_cnt++; if (busy !== 1'b0)      $display("FAIL b2b_busy: got %b want 0", busy);              else pass_cnt++;
    ready = 1'b0;
  endtask
`else
  task automatic test_continuous();
    int n;
    ready = 1'b1;
    pattern = 16'h1234;
    do_reset();
    // do_reset already spent one edge after release.
    n = 1;
    for (int i = 2; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        break;
      end
    end
    total_cnt++; if (n != 134)           $display("FAIL cont_first: got %0d want 134", n);      else pass_cnt++;
    total_cnt++; if (data !== 16'h1234)  $display("FAIL cont_first_data: got %h want 1234", data); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 1; i <= 300; i++) begin
        @(posedge clk);
        #1;
        if (valid) begin
          n = i;
          break;
        end
      end
      total_cnt++; if (n != 133)          $display("FAIL cont_period: got %0d want 133", n);    else pass_cnt++;
      total_cnt++; if (data !== 16'h1234) $display("FAIL cont_data: got %h want 1234", data);   else pass_cnt++;
      total_cnt++; if (busy !== 1'b1)     $display("FAIL cont_busy: got %b want 1", busy);      else pass_cnt++;
    end
    total_cnt++; if (overrun !== 1'b0)   $display("FAIL cont_no_overrun: got %b want 0", overrun); else pass_cnt++;
    ready = 1'b0;
    repeat (140) @(posedge clk);
    #1;
    total_cnt++; if (overrun !== 1'b1)   $display("FAIL cont_overrun: got %b want 1", overrun); else pass_cnt++;
    total_cnt++; if (valid !== 1'b1)     $display("FAIL cont_valid_held: got %b want 1", valid); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
`ifndef SHIFTREG_READER_CONT_EN
    test_latency();
    test_overrun();
    test_ready_at_done();
    test_reset_mid_scan();
    test_back_to_back();
`else
    test_continuous();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shiftreg_chain_reader.md
Name: shiftreg_chain_reader

Overview:
Reads an external 74HC165-style parallel-in/serial-out shift-register chain and presents each captured frame as a parallel word.
- Each scan: assert parallel-load, release it, clock the chain WIDTH times, assemble the serial bits MSB-first.
- Output uses a valid/ready handshake.
- This is the capture-side counterpart of the shift-out chain driver in the same test harness, and sits between the TT user pins (sclk/pl_n/sdi) and on-chip logic.

Parameters:
- WIDTH, 16, number of bits in the external chain (2..32).
- CLK_DIV, 4, system clocks per sclk half-period, also the load and settle phase lengths (>=3).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one scan; sampled only in IDLE
- sclk  output  1  chain shift clock; chain shifts on its rising edge
- pl_n  output  1  chain parallel-load, active low
- sdi  input  1  chain serial output (Q7), asynchronous to clk
- data  output  WIDTH  captured frame, MSB = first bit shifted out
- valid  output  1  data holds an unconsumed frame
- ready  input  1  consumer accepts data when valid && ready
- busy  output  1  scan in progress (state != IDLE)
- overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- Reset (async, rst_n=0): all outputs registered, with these values:
  - state=IDLE, sclk=0, pl_n=1, data=0, valid=0, busy=0, overrun=0.
  - Internal shift register, bit counter and divider counter = 0.
  - Reset mid-scan aborts immediately; no partial frame is ever presented.
- sdi passes through a 2-FF synchronizer. All sampling uses the synchronized value.
- FSM states: IDLE, LOAD, SETTLE, LOW, HIGH, DONE.
  - IDLE: start=1 -> LOAD on next edge. start in any other state is ignored.
  - LOAD: pl_n=0 for CLK_DIV cycles -> SETTLE.
  - SETTLE: pl_n=1, sclk=0 for CLK_DIV cycles -> LOW with bit count 0.
  - LOW: sclk=0 for CLK_DIV cycles. On the last cycle, shift synced sdi into the LSB of the internal register (shift left) and increment the bit count.
    - If bit count now == WIDTH -> DONE.
    - Otherwise -> HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles -> LOW.
  - Exactly WIDTH-1 sclk rising edges are produced per scan.
  - DONE (1 cycle): frame is complete -> IDLE.
    - If valid=0, or valid=1 && ready=1 in the same cycle: data <= frame, valid <= 1.
    - Otherwise (valid=1, ready=0): frame discarded, data unchanged, overrun <= 1.
- Latency: valid rises 2*CLK_DIV + WIDTH*CLK_DIV + (WIDTH-1)*CLK_DIV + 1 clocks after the start-accepting edge. With defaults that is 133.
- Handshake:
  - valid falls on the edge where valid && ready, except when DONE reloads it that same cycle.
  - data is stable while valid=1.
  - ready has no effect when valid=0.
- overrun is cleared only by reset.
- busy is a registered decode of state != IDLE: 1 from LOAD through DONE.
- sclk and pl_n are glitch-free, driven directly from flops.

Optional Feature:
Macro SHIFTREG_READER_CONT_EN.
- Defined: free-running scan. DONE goes to LOAD instead of IDLE, and IDLE -> LOAD occurs unconditionally after reset; start is ignored.
  - busy stays 1 after the first scan begins.
  - The overrun rules are unchanged, so a slow consumer sees overrun=1.
- Not defined: one scan per start pulse, exactly as above.

Test Plan:
- Chain model preloaded 0xA5C3, start pulse, ready=1 -> valid rises exactly 133 clocks later, data=0xA5C3; 15 sclk rising edges; one pl_n low pulse of 4 clocks.
- Two scans, patterns 0x0001 then 0x8000, ready held 0 after the first -> data stays 0x0001, valid stays 1, overrun=1 after the second DONE; then ready=1 -> valid=0 on the next edge.
- ready asserted in the same cycle as DONE of a second scan (first still pending) -> second frame loaded, valid stays 1, overrun stays 0.
- rst_n pulsed low at bit 7 of a scan -> outputs immediately sclk=0, pl_n=1, busy=0, valid=0; a following start with 0xFFFF yields data=0xFFFF.
- start held high continuously, CONT_EN off -> back-to-back scans; start pulses during busy ignored (scan count matches IDLE entries).
- Build with SHIFTREG_READER_CONT_EN, chain 0x1234, ready=1 -> valid pulses every 133 clocks with data=0x1234; start tied 0.
